// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and defaults for the skid-buffered pipeline stages
package pipe_pkg;

  // Encoding equals the occupancy, so count can be read straight off the state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  localparam logic [31:0] DEFAULT_NOP_IR = 32'h0000_0000;

  function automatic logic [1:0] count_of(input skid_state_e st);
    case (st)
      ST_ONE:  return 2'd1;
      ST_FULL: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/if_id_skid_stage.sv
// rtl/if_id_skid_stage.sv - two-entry skid-buffered IF/ID stage carrying {pc, ir} with flush
module if_id_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned          pc_size    = 18,
  parameter int unsigned          data_size  = 32,
  parameter logic [data_size-1:0] NOP_IR     = data_size'(DEFAULT_NOP_IR),
  parameter int unsigned          FLUSH_MODE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [pc_size-1:0]   in_pc,
  input  logic [data_size-1:0] in_ir,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [pc_size-1:0]   out_pc,
  output logic [data_size-1:0] out_ir,
  output logic                 out_bubble,
  output logic [1:0]           count
);

  skid_state_e          state_q;
  logic [pc_size-1:0]   main_pc_q, skid_pc_q;
  logic [data_size-1:0] main_ir_q, skid_ir_q;
  logic                 main_bub_q, skid_bub_q;
  logic                 hold_q;

  logic in_xfer, out_xfer;

  // in_ready depends on registered state only, so decode stalls never reach fetch.
  assign in_ready   = rst & (state_q != ST_FULL);
  assign out_valid  = (state_q != ST_EMPTY);
  assign in_xfer    = in_valid & in_ready;
  assign out_xfer   = out_valid & out_ready;
  assign out_pc     = main_pc_q;
  assign out_ir     = main_ir_q;
  assign out_bubble = main_bub_q;
  assign count      = count_of(state_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      main_pc_q  <= '0;
      main_ir_q  <= '0;
      main_bub_q <= 1'b0;
      skid_pc_q  <= '0;
      skid_ir_q  <= '0;
      skid_bub_q <= 1'b0;
    end else if (flush) begin
      // Any out_xfer this cycle already delivered the head; an accepted in_xfer is discarded.
      if (FLUSH_MODE == 0) begin
        state_q <= ST_EMPTY;
      end else begin
        state_q    <= ST_ONE;
        main_pc_q  <= in_pc;
        main_ir_q  <= NOP_IR;
        main_bub_q <= 1'b1;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_pc_q  <= in_pc;
            main_ir_q  <= in_ir;
            main_bub_q <= 1'b0;
            state_q    <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_xfer && !out_xfer) begin
            skid_pc_q  <= in_pc;
            skid_ir_q  <= in_ir;
            skid_bub_q <= 1'b0;
            state_q    <= ST_FULL;
          end else if (in_xfer && out_xfer) begin
            main_pc_q  <= in_pc;
            main_ir_q  <= in_ir;
            main_bub_q <= 1'b0;
          end else if (out_xfer) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            main_pc_q  <= skid_pc_q;
            main_ir_q  <= skid_ir_q;
            main_bub_q <= skid_bub_q;
            state_q    <= ST_ONE;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  // hold_q marks a cycle that stalled in FULL; the state seen one edge later must still be FULL.
  always_ff @(posedge clk) begin
    hold_q <= rst & (state_q == ST_FULL) & !out_ready & !flush;
    if (hold_q) assert (state_q == ST_FULL);
    if (state_q == ST_FULL) assert (!in_ready);
    assert (count == count_of(state_q));
    assert (state_q != 2'd3);
  end

endmodule

// File: doc/if_id_skid_stage.md
Name: if_id_skid_stage

Overview:
- Parametrised successor to the IF/ID pipeline latch: a two-entry skid-buffered pipeline stage carrying {pc, ir} between fetch and decode.
- Uses a valid/ready handshake on both sides, so a decode stall never combinationally reaches fetch.
- Adds a configurable flush that either drops the stage contents or injects a bubble carrying the PC.
- Sits between the fetch unit and the decode/hazard logic.

Parameters:
- pc_size, 18, width of the PC field
- data_size, 32, width of the instruction field
- NOP_IR, 0, instruction encoding injected as a bubble
- FLUSH_MODE, 1, 0 = flush empties the stage; 1 = flush leaves one bubble (ir = NOP_IR, pc = in_pc)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset
- in_valid  in  1  fetch presents in_pc/in_ir
- in_ready  out  1  stage can accept; driven from state only
- in_pc  in  pc_size  fetched PC
- in_ir  in  data_size  fetched instruction
- flush  in  1  squash request (branch/jump taken)
- out_valid  out  1  out_pc/out_ir valid
- out_ready  in  1  decode accepts this cycle
- out_pc  out  pc_size  head entry PC
- out_ir  out  data_size  head entry instruction
- out_bubble  out  1  head entry is an injected bubble
- count  out  2  occupancy, 0..2

Behaviour:
- Transfer definitions:
  - in_xfer = in_valid & in_ready
  - out_xfer = out_valid & out_ready
- Storage: main entry (head) and skid entry, each holding {pc, ir, bubble}.
- States: EMPTY (count 0), ONE (main valid), FULL (main and skid valid).
- out_valid = (state != EMPTY). out_* always show the main entry.
- in_ready = rst & (state != FULL). There is no combinational path from out_ready or flush to in_ready.
- Reset (rst low at a rising edge):
  - state = EMPTY; count = 0; out_valid = 0
  - out_pc = 0; out_ir = 0; out_bubble = 0
  - skid contents = 0
  - in_ready is 0 while rst is low.
  - Reset overrides flush and all handshakes. Reset mid-stall discards both entries.
- Transitions without flush:
  - EMPTY, in_xfer: main <= in, go to ONE.
  - ONE, in_xfer & !out_xfer: skid <= in, go to FULL.
  - ONE, in_xfer & out_xfer: main <= in, stay in ONE (full throughput, 1 entry/cycle).
  - ONE, !in_xfer & out_xfer: go to EMPTY.
  - FULL, out_xfer: main <= skid, go to ONE. in_xfer cannot occur in FULL.
  - Any other combination: hold all contents.
- Latency: 1 cycle from in_xfer to out_valid when EMPTY. Ordering is strictly FIFO.
- Flush (priority over the normal transitions, below reset):
  - An out_xfer in the flush cycle completes normally; decode owns that entry.
  - An in_xfer in the flush cycle is accepted and discarded.
  - FLUSH_MODE 0: next state EMPTY; both entries dropped.
  - FLUSH_MODE 1: next state ONE with main = {in_pc, NOP_IR, bubble = 1}; skid dropped. in_pc is sampled whether or not in_valid is high.
  - flush held for several cycles repeats this action every cycle.
- Bubbles obey the handshake like ordinary entries. out_bubble = 0 for every entry loaded from in_*.
- count = number of valid entries; it changes only at rising edges.
- Assertions:
  - No state change in FULL when out_ready = 0 and flush = 0.
  - in_ready = 0 in FULL.
  - count matches state.

Decomposition:
- Shared package (pipe_pkg): state encoding EMPTY/ONE/FULL (2-bit) and the default NOP_IR constant, reused by the later ID/EX and EX/MEM skid stages.
- No sub-module: the two entries are plain registers in one module.
- Expected size: about 150–220 lines of RTL.

Test Plan:
- Reset: rst low for 2 cycles with in_valid = 1 and flush = 1 -> out_valid = 0, count = 0, out_ir = 0, in_ready = 0; one cycle after rst rises, in_ready = 1.
- Streaming: out_ready = 1; send pc = 0x00004, 0x00008, 0x0000C with ir = 0x8C010000, 0x8C020004, 0x00221820 on consecutive cycles -> each appears on out_* one cycle later, no gaps, count stays 1.
- Backpressure: out_ready = 0, push pc = 0x10 then 0x14 -> count = 2, in_ready = 0, in_valid held with pc = 0x18 is not accepted. Raise out_ready -> outputs 0x10, 0x14, 0x18 in order, none lost or duplicated.
- Flush mode 1 in FULL: flush = 1, in_pc = 0x20, out_ready = 0 -> next cycle count = 1, out_pc = 0x20, out_ir = NOP_IR, out_bubble = 1; both buffered entries are gone.
- Flush mode 0 (FLUSH_MODE = 0): state ONE, flush coinciding with in_xfer of pc = 0x24 -> next cycle count = 0, out_valid = 0, and 0x24 never appears on out_*.
- Simultaneous flush and out_xfer in ONE: the head entry is consumed that cycle (decode sees it once); the next head is the bubble in mode 1, or the stage is empty in mode 0.
